// File: rtl/debug_halt_ctrl.sv
// Run/halt controller between the debug interface and the CPU pipeline.
// Gates pipeline advance and reports halt status, cause, halt PC and retire count.
module debug_halt_ctrl #(
  parameter int unsigned PC_WIDTH  = 64,
  parameter int unsigned CNT_WIDTH = 32,
  parameter int unsigned DRAIN_MAX = 4
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_test_halt,
  input  logic                 i_resume_req,
  input  logic                 i_step_req,
  input  logic                 i_retire,
  input  logic                 i_retire_hlt,
  input  logic [PC_WIDTH-1:0]  i_retire_pc,
  output logic                 o_run_en,
  output logic                 o_halted,
  output logic [1:0]           o_halt_cause,
  output logic [PC_WIDTH-1:0]  o_halt_pc,
  output logic [CNT_WIDTH-1:0] o_retired_count
);

  localparam int unsigned DrainW = (DRAIN_MAX > 1) ? $clog2(DRAIN_MAX) : 1;

  localparam logic [1:0] CauseNone = 2'd0;
  localparam logic [1:0] CauseExt  = 2'd1;
  localparam logic [1:0] CauseHlt  = 2'd2;
  localparam logic [1:0] CauseStep = 2'd3;

  typedef enum logic [1:0] {StRun, StDrain, StHalted, StStep} state_t;

  state_t               r_state,     w_state_d;
  logic [DrainW-1:0]    r_drain_cnt, w_drain_cnt_d;
  logic [1:0]           r_pend,      w_pend_d;
  logic [1:0]           r_cause,     w_cause_d;
  logic [PC_WIDTH-1:0]  r_halt_pc,   w_halt_pc_d;
  logic [PC_WIDTH-1:0]  r_last_pc;
  logic [CNT_WIDTH-1:0] r_count;
  logic                 r_run_en;
  logic                 r_halted;

  logic                 w_hlt;
  logic                 w_drain_done;
  logic [PC_WIDTH-1:0]  w_pc_now;

  assign w_hlt        = i_retire & i_retire_hlt;
  assign w_drain_done = (r_drain_cnt == DrainW'(DRAIN_MAX - 1));
  // A retire in the final drain cycle is the last insn before the halt.
  assign w_pc_now     = i_retire ? i_retire_pc : r_last_pc;

  always_comb begin
    w_state_d     = r_state;
    w_drain_cnt_d = r_drain_cnt;
    w_pend_d      = r_pend;
    w_cause_d     = r_cause;
    w_halt_pc_d   = r_halt_pc;
    unique case (r_state)
      StRun: begin
        if (w_hlt) begin
          w_state_d   = StHalted;
          w_cause_d   = CauseHlt;
          w_halt_pc_d = i_retire_pc;
        end else if (i_test_halt) begin
          w_state_d     = StDrain;
          w_drain_cnt_d = '0;
          w_pend_d      = CauseExt;
        end
      end
      StDrain: begin
        if (w_hlt) begin
          w_state_d   = StHalted;
          w_cause_d   = CauseHlt;
          w_halt_pc_d = i_retire_pc;
        end else if (w_drain_done) begin
          w_state_d   = StHalted;
          w_cause_d   = r_pend;
          w_halt_pc_d = w_pc_now;
        end else begin
          w_drain_cnt_d = r_drain_cnt + DrainW'(1);
        end
      end
      StHalted: begin
        // The level halt request blocks resume but not a single step.
        if (i_resume_req && !i_test_halt) begin
          w_state_d = StRun;
          w_cause_d = CauseNone;
        end else if (i_step_req) begin
          w_state_d = StStep;
          w_cause_d = CauseNone;
        end
      end
      StStep: begin
        if (w_hlt) begin
          w_state_d   = StHalted;
          w_cause_d   = CauseHlt;
          w_halt_pc_d = i_retire_pc;
        end else begin
          w_state_d     = StDrain;
          w_drain_cnt_d = '0;
          w_pend_d      = CauseStep;
        end
      end
      default: w_state_d = StRun;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= StRun;
      r_drain_cnt <= '0;
      r_pend      <= CauseNone;
      r_cause     <= CauseNone;
      r_halt_pc   <= '0;
      r_last_pc   <= '0;
      r_count     <= '0;
      r_run_en    <= 1'b0;
      r_halted    <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_drain_cnt <= w_drain_cnt_d;
      r_pend      <= w_pend_d;
      r_cause     <= w_cause_d;
      r_halt_pc   <= w_halt_pc_d;
      r_run_en    <= (w_state_d == StRun) || (w_state_d == StStep);
      r_halted    <= (w_state_d == StHalted);
      if (i_retire) begin
        r_count   <= r_count + CNT_WIDTH'(1);
        r_last_pc <= i_retire_pc;
      end
    end
  end

  assign o_run_en        = r_run_en;
  assign o_halted        = r_halted;
  assign o_halt_cause    = r_cause;
  assign o_halt_pc       = r_halt_pc;
  assign o_retired_count = r_count;

endmodule

// File: tb/tb_debug_halt_ctrl.sv
// Bench for debug_halt_ctrl: directed scenarios with literal expectations, then random
// stimulus checked every cycle against a timeline-based reference model.
module tb_debug_halt_ctrl;

  localparam int unsigned PC_W  = 64;
  localparam int unsigned CNT_W = 10;
  localparam int unsigned DMAX  = 4;

  localparam int MRun    = 0;
  localparam int MDrain  = 1;
  localparam int MHalted = 2;
  localparam int MStep   = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             test_halt;
  logic             resume_req;
  logic             step_req;
  logic             retire;
  logic             retire_hlt;
  logic [PC_W-1:0]  retire_pc;
  logic             run_en;
  logic             halted;
  logic [1:0]       halt_cause;
  logic [PC_W-1:0]  halt_pc;
  logic [CNT_W-1:0] retired_count;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: mode plus the absolute cycle at which a drain ends.
  int              m_cyc = 0;
  int              m_mode = MRun;
  int              m_drain_end = 0;
  int              m_pend = 0;
  int              m_cause = 0;
  logic [63:0]     m_hpc = '0;
  logic [63:0]     m_last = '0;
  int unsigned     m_count = 0;
  bit              m_rst = 1'b1;

  debug_halt_ctrl #(
    .PC_WIDTH (PC_W),
    .CNT_WIDTH(CNT_W),
    .DRAIN_MAX(DMAX)
  ) u_dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_test_halt    (test_halt),
    .i_resume_req   (resume_req),
    .i_step_req     (step_req),
    .i_retire       (retire),
    .i_retire_hlt   (retire_hlt),
    .i_retire_pc    (retire_pc),
    .o_run_en       (run_en),
    .o_halted       (halted),
    .o_halt_cause   (halt_cause),
    .o_halt_pc      (halt_pc),
    .o_retired_count(retired_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic halt_to(input int cause, input logic [63:0] pc);
    m_mode  = MHalted;
    m_cause = cause;
    m_hpc   = pc;
  endtask

  // Expected effect of the inputs currently applied, at the coming posedge.
  task automatic model_step();
    logic [63:0] pc_now;
    bit          hlt;
    m_cyc++;
    if (reset) begin
      m_mode = MRun; m_cause = 0; m_hpc = '0; m_last = '0; m_count = 0; m_rst = 1'b1;
    end else begin
      m_rst  = 1'b0;
      hlt    = retire && retire_hlt;
      pc_now = retire ? retire_pc : m_last;
      case (m_mode)
        MRun: begin
          if (hlt) halt_to(2, retire_pc);
          else if (test_halt) begin
            m_mode = MDrain; m_drain_end = m_cyc + int'(DMAX); m_pend = 1;
          end
        end
        MDrain: begin
          if (hlt) halt_to(2, retire_pc);
          else if (m_cyc == m_drain_end) halt_to(m_pend, pc_now);
        end
        MHalted: begin
          if (resume_req && !test_halt) m_mode = MRun;
          else if (step_req) m_mode = MStep;
        end
        default: begin
          if (hlt) halt_to(2, retire_pc);
          else begin
            m_mode = MDrain; m_drain_end = m_cyc + int'(DMAX); m_pend = 3;
          end
        end
      endcase
      if (retire) begin
        m_count = (m_count + 1) & ((32'd1 << CNT_W) - 1);
        m_last  = retire_pc;
      end
    end
  endtask

  task automatic compare();
    bit exp_run;
    bit exp_halt;
    exp_run  = !m_rst && (m_mode == MRun || m_mode == MStep);
    exp_halt = (m_mode == MHalted);
    chk("model run_en", 64'(run_en), 64'(exp_run));
    chk("model halted", 64'(halted), 64'(exp_halt));
    chk("model cause", 64'(halt_cause), exp_halt ? 64'(m_cause) : 64'd0);
    chk("model halt_pc", halt_pc, m_hpc);
    chk("model count", 64'(retired_count), 64'(m_count));
    chk("never halted and run_en", 64'(halted && run_en), 64'd0);
  endtask

  task automatic tick();
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic do_retire(input logic [63:0] pc, input bit hlt);
    retire = 1'b1; retire_hlt = hlt; retire_pc = pc;
    tick();
    retire = 1'b0; retire_hlt = 1'b0;
  endtask

  task automatic pulse_resume();
    resume_req = 1'b1; tick(); resume_req = 1'b0;
  endtask

  initial begin
    reset = 1'b1; test_halt = 1'b0; resume_req = 1'b0; step_req = 1'b0;
    retire = 1'b0; retire_hlt = 1'b0; retire_pc = '0;

    // 1: reset and release
    repeat (3) tick();
    chk("reset run_en", 64'(run_en), 64'd0);
    chk("reset halted", 64'(halted), 64'd0);
    reset = 1'b0;
    tick();
    chk("release run_en", 64'(run_en), 64'd1);
    chk("release count", 64'(retired_count), 64'd0);

    // 2: external halt after five retires
    for (int i = 0; i < 5; i++) do_retire(64'h30 + 64'(4 * i), 1'b0);
    test_halt = 1'b1;
    tick();
    chk("drain run_en", 64'(run_en), 64'd0);
    repeat (3) tick();
    chk("drain not yet halted", 64'(halted), 64'd0);
    tick();
    chk("ext halted", 64'(halted), 64'd1);
    chk("ext cause", 64'(halt_cause), 64'd1);
    chk("ext halt_pc", halt_pc, 64'h40);
    chk("ext count", 64'(retired_count), 64'd5);

    // 3: HLT retire, alone and together with test_halt
    test_halt = 1'b0;
    pulse_resume();
    chk("resume run_en", 64'(run_en), 64'd1);
    do_retire(64'h1C, 1'b1);
    chk("hlt halted", 64'(halted), 64'd1);
    chk("hlt cause", 64'(halt_cause), 64'd2);
    chk("hlt halt_pc", halt_pc, 64'h1C);
    chk("hlt run_en", 64'(run_en), 64'd0);
    pulse_resume();
    test_halt = 1'b1;
    do_retire(64'h1C, 1'b1);
    chk("hlt beats ext cause", 64'(halt_cause), 64'd2);

    // 4: resume blocked by level request, single step
    pulse_resume();
    chk("blocked resume halted", 64'(halted), 64'd1);
    step_req = 1'b1; tick(); step_req = 1'b0;
    chk("step run_en", 64'(run_en), 64'd1);
    chk("step halted", 64'(halted), 64'd0);
    do_retire(64'h20, 1'b0);
    chk("step run_en one cycle", 64'(run_en), 64'd0);
    repeat (3) tick();
    chk("step drain not halted", 64'(halted), 64'd0);
    tick();
    chk("step halted", 64'(halted), 64'd1);
    chk("step cause", 64'(halt_cause), 64'd3);
    chk("step halt_pc", halt_pc, 64'h20);
    chk("step count", 64'(retired_count), 64'd8);

    // 5: resume, then counter wrap
    test_halt = 1'b0;
    pulse_resume();
    chk("resume halted", 64'(halted), 64'd0);
    chk("resume cause", 64'(halt_cause), 64'd0);
    chk("resume run_en", 64'(run_en), 64'd1);
    for (int i = 0; i < 1015; i++) do_retire(64'h1000 + 64'(i), 1'b0);
    chk("count at max", 64'(retired_count), 64'h3FF);
    do_retire(64'h2000, 1'b0);
    chk("count wrap", 64'(retired_count), 64'd0);

    // 6: reset mid-drain and while halted
    test_halt = 1'b1;
    repeat (2) tick();
    reset = 1'b1; tick();
    chk("rst drain run_en", 64'(run_en), 64'd0);
    chk("rst drain halted", 64'(halted), 64'd0);
    chk("rst drain pc", halt_pc, 64'd0);
    test_halt = 1'b0; reset = 1'b0; tick();
    chk("rst drain rerun", 64'(run_en), 64'd1);
    test_halt = 1'b1;
    repeat (6) tick();
    chk("pre-reset halted", 64'(halted), 64'd1);
    reset = 1'b1; tick();
    chk("rst halted halted", 64'(halted), 64'd0);
    chk("rst halted cause", 64'(halt_cause), 64'd0);
    test_halt = 1'b0; reset = 1'b0; tick();
    chk("rst halted rerun", 64'(run_en), 64'd1);

    // Random phase
    for (int i = 0; i < 4000; i++) begin
      reset      = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 99) < 6) test_halt = ~test_halt;
      resume_req = ($urandom_range(0, 99) < 12);
      step_req   = ($urandom_range(0, 99) < 12);
      retire     = ($urandom_range(0, 99) < 40);
      retire_hlt = ($urandom_range(0, 99) < 6);
      retire_pc  = {$urandom, $urandom};
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
